// File: rtl/muldiv_pkg.sv
// Shared constants and state type for the multi-cycle multiply/divide sequencer.
// Imported by the sequencer top and its negate helper.
package muldiv_pkg;

    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b000001;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } st_t;

endpackage

// File: rtl/muldiv_negate.sv
// Width-parameterised conditional two's-complement negate.
// Used for operand magnitudes and final sign correction.
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic         i_en,
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_y
);

    assign o_y = i_en ? ({W{1'b0}} - i_x) : i_x;

endmodule

// File: rtl/alu_muldiv_seq.sv
// MIPS HI/LO multiply/divide sequencer: one shared-ALU add/subtract per cycle,
// magnitude arithmetic with a final sign fix-up cycle.
module alu_muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_fun,
    output logic        alu_sign,
    input  logic [31:0] alu_z
);

    localparam logic [4:0] LAST = 5'(ITER - 1);

    st_t         r_state;
    st_t         w_next;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_sa;
    logic        r_sb;
    logic [31:0] r_acc_hi;
    logic [31:0] r_acc_lo;
    logic [31:0] r_d;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_signed;
    logic        w_sa;
    logic        w_sb;
    logic        w_div0;
    logic [31:0] w_abs_rs;
    logic [31:0] w_abs_rt;
    logic [31:0] w_s;
    logic        w_take;
    logic        w_carry;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_signed = ~op[0];
    assign w_sa     = rs[31] & w_signed;
    assign w_sb     = rt[31] & w_signed;
    assign w_div0   = op[1] & (rt == 32'd0);

    muldiv_negate #(.W(32)) u_mag_a (.i_en(w_sa), .i_x(rs), .o_y(w_abs_rs));
    muldiv_negate #(.W(32)) u_mag_b (.i_en(w_sb), .i_x(rt), .o_y(w_abs_rt));

    muldiv_negate #(.W(64)) u_fix_p (
        .i_en(r_sa ^ r_sb),
        .i_x ({r_acc_hi, r_acc_lo}),
        .o_y (w_prod)
    );
    muldiv_negate #(.W(32)) u_fix_q (.i_en(r_sa ^ r_sb), .i_x(r_acc_lo), .o_y(w_quo));
    muldiv_negate #(.W(32)) u_fix_r (.i_en(r_sa), .i_x(r_acc_hi), .o_y(w_rem));

    // Divide: shifted remainder and the bit that fell off its top
    assign w_s     = {r_acc_hi[30:0], r_acc_lo[31]};
    assign w_take  = r_acc_hi[31] | (w_s >= r_d);
    assign w_carry = alu_z < r_acc_hi;

    always_comb begin
        w_next   = r_state;
        alu_a    = 32'd0;
        alu_b    = 32'd0;
        alu_fun  = ALU_ADD;
        alu_sign = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = w_div0 ? ST_DONE : ST_ITER;
                end
            end
            ST_ITER: begin
                alu_a   = r_is_div ? w_s : r_acc_hi;
                alu_b   = r_d;
                alu_fun = r_is_div ? ALU_SUB : ALU_ADD;
                if (r_cnt == LAST) begin
                    w_next = ST_FIX;
                end
            end
            ST_FIX:  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 5'd0;
            r_is_div <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_acc_hi <= 32'd0;
            r_acc_lo <= 32'd0;
            r_d      <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_is_div <= op[1];
                        r_sa     <= w_sa;
                        r_sb     <= w_sb;
                        r_cnt    <= 5'd0;
                        r_acc_hi <= 32'd0;
                        r_acc_lo <= w_abs_rs;
                        r_d      <= w_abs_rt;
                        if (w_div0) begin
                            r_hi <= rs;
                            r_lo <= 32'hFFFF_FFFF;
                        end
                    end
                end
                ST_ITER: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_is_div) begin
                        r_acc_hi <= w_take ? alu_z : w_s;
                        r_acc_lo <= {r_acc_lo[30:0], w_take};
                    end else if (r_acc_lo[0]) begin
                        {r_acc_hi, r_acc_lo} <= {w_carry, alu_z, r_acc_lo[31:1]};
                    end else begin
                        {r_acc_hi, r_acc_lo} <= {1'b0, r_acc_hi, r_acc_lo[31:1]};
                    end
                end
                ST_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural ALU and
// an expected-result queue popped on each done pulse.
module tb_alu_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs = 32'd0;
    logic [31:0] rt = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_fun;
    logic        alu_sign;
    logic [31:0] alu_z;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    alu_muldiv_seq #(.ITER(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs      (rs),
        .rt      (rt),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_fun (alu_fun),
        .alu_sign(alu_sign),
        .alu_z   (alu_z)
    );

    always #5 clk = ~clk;

    assign alu_z = (alu_fun == ALU_SUB) ? alu_a - alu_b : alu_a + alu_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] pa, pb;
        logic [31:0] ma, mb, q, r;
        logic        sa, sb;
        if (!o[1]) begin
            pa = o[0] ? {32'd0, a} : {{32{a[31]}}, a};
            pb = o[0] ? {32'd0, b} : {{32{b[31]}}, b};
            return pa * pb;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sa = !o[0] && a[31];
        sb = !o[0] && b[31];
        ma = sa ? 32'd0 - a : a;
        mb = sb ? 32'd0 - b : b;
        q  = ma / mb;
        r  = ma % mb;
        return {sa ? 32'd0 - r : r, (sa ^ sb) ? 32'd0 - q : q};
    endfunction

    task automatic issue(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
        exp_t e;
        @(negedge clk);
        op    = o;
        rs    = a;
        rt    = b;
        start = 1'b1;
        e.tag = tag;
        e.hi  = exp[63:32];
        e.lo  = exp[31:0];
        e.lat = lat;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs from cycle 1 until done; optional start pulse or reset at a given cycle.
    task automatic collect(input int pulse_at, input int rst_at);
        exp_t e;
        int   n;
        bit   got, bad_busy, alu_act;
        n = 1; got = 0; bad_busy = 0; alu_act = 0;
        while (n <= 60) begin
            start = (n == pulse_at);
            if (start) begin
                op = OP_MULTU; rs = 32'd123; rt = 32'd456;
            end
            if (n == rst_at) begin
                reset = 1'b1;
                #1;
                chk("rst_busy", {63'd0, busy}, 64'd0);
                chk("rst_done", {63'd0, done}, 64'd0);
                chk("rst_hilo", {hi, lo}, 64'd0);
                chk("rst_alu", {alu_a, alu_b}, 64'd0);
                if (sb_q.size() > 0) void'(sb_q.pop_front());
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (!busy) bad_busy = 1;
            if (alu_a != 0 || alu_b != 0 || alu_fun != 0 || alu_sign != 0) alu_act = 1;
            if (done) begin
                got = 1;
                break;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("done_seen", {63'd0, got}, 64'd1);
        if (sb_q.size() == 0) begin
            chk("queue_empty", 64'd1, 64'd0);
            return;
        end
        e = sb_q.pop_front();
        if (!got) return;
        chk({e.tag, "_lat"}, 64'(n), 64'(e.lat));
        chk({e.tag, "_hilo"}, {hi, lo}, {e.hi, e.lo});
        chk({e.tag, "_busy"}, {63'd0, bad_busy}, 64'd0);
        if (e.lat == 1) chk({e.tag, "_alu_idle"}, {63'd0, alu_act}, 64'd0);
        @(negedge clk);
        chk({e.tag, "_after"}, {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        #12;
        chk("reset_out", {hi, lo}, 64'd0);
        chk("reset_ctl", {61'd0, busy, done, alu_sign}, 64'd0);
        chk("reset_alu", {alu_a, alu_b}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        issue("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              64'hFFFF_FFFE_0000_0001, 34);
        collect(0, 0);
        issue("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 34);
        collect(0, 0);
        issue("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000,
              64'h4000_0000_0000_0000, 34);
        collect(0, 0);
        issue("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
        collect(0, 0);
        issue("divu_100_7", OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 34);
        collect(0, 0);
        issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 34);
        collect(0, 0);
        issue("divu_zero", OP_DIVU, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1);
        collect(0, 0);
        issue("mult_ign", OP_MULT, 32'd1234, 32'hFFFF_E9D2,
              model(OP_MULT, 32'd1234, 32'hFFFF_E9D2), 34);
        collect(10, 0);
        issue("divu_rst", OP_DIVU, 32'd1000, 32'd3, model(OP_DIVU, 32'd1000, 32'd3), 34);
        collect(0, 20);
        issue("multu_6_7", OP_MULTU, 32'd6, 32'd7, {32'd0, 32'd42}, 34);
        collect(0, 0);

        for (int i = 0; i < 6; i++) begin
            ro = 2'(i % 4);
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : $urandom;
            if (i == 4) rb = {28'd0, rb[3:0]} | 32'd1;
            issue("rand", ro, ra, rb, model(ro, ra, rb), (ro[1] && rb == 0) ? 1 : 34);
            collect(0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Multi-cycle multiply/divide sequencer that produces MIPS HI/LO results for MULT, MULTU, DIV and DIVU by driving the shared 32-bit ALU one add or subtract per cycle. It sits beside the ALU in the execute stage. While `busy` is high it owns the ALU operand and function inputs, and the pipeline stalls. It computes on magnitudes and applies sign correction in a final fix-up cycle.

## Interface
Parameters:
- `ITER`, 32: number of iteration cycles; equals the operand width and is fixed at 32.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs`  in  32  multiplicand or dividend.
- `rt`  in  32  multiplier or divisor.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid from this cycle.
- `hi`  out  32  product high word or remainder.
- `lo`  out  32  product low word or quotient.
- `alu_a`  out  32  ALU operand A.
- `alu_b`  out  32  ALU operand B.
- `alu_fun`  out  6  ALU function code.
- `alu_sign`  out  1  ALU Sign input; this block always drives 0.
- `alu_z`  in  32  ALU result, combinational from `alu_a`/`alu_b`/`alu_fun`.

## Operation
- States: IDLE, ITER, FIX, DONE.
- IDLE with `start`=1 latches the following, then enters ITER with counter = 0:
  - `op`.
  - Operand signs `sa` = rs[31] and `sb` = rt[31]; both forced to 0 for unsigned ops.
  - Magnitudes |rs| and |rt|. |x| is the two's-complement negate of x when its sign bit is set.
- DIV/DIVU with rt = 0 skips ITER and FIX and goes straight to DONE with hi = rs and lo = 32'hFFFFFFFF. No sign correction is applied.
- Multiply (shift-add; accumulator {P_hi, P_lo}, P_lo initialised to |rs|, P_hi = 0):
  - ALU is driven with `alu_a` = P_hi, `alu_b` = |rt|, `alu_fun` = 6'b000000 (ADD).
  - If P_lo[0] = 1: carry = (alu_z < P_hi), using a local unsigned compare. Then {carry, alu_z, P_lo} >> 1.
  - If P_lo[0] = 0: {1'b0, P_hi, P_lo} >> 1.
- Divide (restoring; remainder R = 0, quotient Q = |rs|, divisor D = |rt|):
  - Form shifted remainder S = {R[30:0], Q[31]} with shifted-out bit c = R[31], and shift Q left by one.
  - ALU is driven with `alu_a` = S, `alu_b` = D, `alu_fun` = 6'b000001 (SUB).
  - If c = 1 or S ≥ D (unsigned): R = alu_z and Q[0] = 1.
  - Otherwise: R = S and Q[0] = 0.
- The counter increments every ITER cycle. At counter = 31, the next state is FIX.
- FIX writes hi/lo:
  - Multiply: {hi, lo} = product, negated as 64 bits if sa^sb.
  - Divide: lo = Q, negated if sa^sb; hi = R, negated if sa.
  - Consequence: 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- DONE asserts `done` for one cycle, then returns to IDLE.
- `start` while not in IDLE is ignored. It is neither queued nor errored.
- Outside ITER, the ALU outputs are `alu_a` = 0, `alu_b` = 0, `alu_fun` = 6'b000000, `alu_sign` = 0.
- `hi`/`lo` hold their last result until the next FIX or the divide-by-zero DONE writes them.

## Timing
- Reset (asynchronous, mid-operation included): state IDLE, `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, ALU outputs at their idle values. Any in-flight operation is discarded.
- Normal operation, with start sampled at edge 0:
  - `busy` = 1 in cycles 1–34.
  - ITER occupies cycles 1–32; FIX is cycle 33; DONE is cycle 34.
  - `done` = 1 in cycle 34, with `hi`/`lo` valid; `busy` drops in cycle 35.
  - Total latency is 34 cycles.
- Divide by zero: DONE is cycle 1 and `done` = 1 in cycle 1. `busy` is 1 in cycle 1 only.
- `busy` = 1 in every non-IDLE state, including DONE.
- A new `start` is accepted at earliest in the cycle after DONE.
- ALU path: `alu_z` is combinational within the cycle; the result is registered at the end of the same ITER cycle.

## Structure
- Shared package `muldiv_pkg` holds:
  - ALUFun constants `ALU_ADD` = 6'b000000 and `ALU_SUB` = 6'b000001.
  - `op` encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`.
  - State enum `st_t`.
- One sub-module, `muldiv_negate`: a width-parameterised two's-complement negate with conditional enable. It is used for operand magnitudes (32-bit) and FIX correction (64-bit and 32-bit).

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001, `done` exactly 34 cycles after start.
- MULT −3 × 7 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; MULT 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0.
- DIV −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU 100 / 7 → lo = 14, hi = 2; DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIVU 5 / 0 → `done` in cycle 1, hi = 5, lo = 0xFFFFFFFF; no ALU activity: `alu_fun`, `alu_a` and `alu_b` stay at their idle values in every cycle.
- `start` pulsed at cycle 10 of a MULT is ignored, and the first result is unchanged.
- `reset` at cycle 20 of a DIVU: `busy`, `done`, `hi`, `lo` = 0 immediately. A fresh MULTU 6 × 7 after reset gives lo = 42.
